// File: rtl/poly_io_sequencer.sv
// poly_io_sequencer
//   Host-side driver for POLY_reg_bank. It takes one valid/ready word stream
//   and writes operands A, B, M and M_prime_0 into the bank, always in that
//   order. On request it drains RES_reg through store_RES_reg_en_o and
//   presents the result as a valid/ready stream.
//
// Ports
//   clock_i, reset_i            clock; synchronous active-high reset
//   load_start_i                pulse that starts an operand load (IDLE only)
//   unload_start_i              pulse that starts a result drain (IDLE only)
//   s_data_i/s_valid_i/s_ready_o   operand input stream
//   m_data_o/m_valid_o/m_ready_i   result output stream, m_last_o on word N*S-1
//   busy_o                      registered, high while not in IDLE
//   load_done_o, unload_done_o  1-cycle completion pulses
//   INPUT_reg_sel_o/_en_o/_din_o   registered bank write port
//   store_RES_reg_en_o          bank RES_reg shift-out enable
//   RES_reg_dout_i              bank RES_reg current LS word
//
// state   | meaning
// IDLE    | waiting for a start pulse
// LOAD_A  | accepting N*S words of A   (sel 00)
// LOAD_B  | accepting N*S words of B   (sel 01)
// LOAD_M  | accepting N*S words of M   (sel 10)
// LOAD_MP | accepting N words of M'_0 (sel 11)
// UNLOAD  | streaming N*S words out of RES_reg
module poly_io_sequencer #(
    parameter int WORD_WIDTH = 17,
    parameter int N          = 5,
    parameter int S          = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_start_i,
    input  logic                  unload_start_i,
    input  logic [WORD_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [WORD_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  load_done_o,
    output logic                  unload_done_o,
    output logic [1:0]            INPUT_reg_sel_o,
    output logic                  INPUT_reg_en_o,
    output logic [WORD_WIDTH-1:0] INPUT_reg_din_o,
    output logic                  store_RES_reg_en_o,
    input  logic [WORD_WIDTH-1:0] RES_reg_dout_i
);

    localparam int WORDS = N * S;
    localparam int CW    = $clog2(WORDS);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, LOAD_M, LOAD_MP, UNLOAD
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [1:0]      sel_cur;
    logic            sect_last;
    logic            accept;
    logic            xfer;

    assign s_ready_o          = (state == LOAD_A) || (state == LOAD_B) ||
                                (state == LOAD_M) || (state == LOAD_MP);
    assign accept             = s_valid_i & s_ready_o;
    assign m_valid_o          = (state == UNLOAD);
    assign m_data_o           = m_valid_o ? RES_reg_dout_i : '0;
    assign m_last_o           = m_valid_o && (count == CW'(WORDS - 1));
    assign xfer               = m_valid_o & m_ready_i;
    assign store_RES_reg_en_o = xfer;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        sel_cur   = 2'b00;
        sect_last = 1'b0;
        case (state)
            IDLE: begin
                if (load_start_i)        state_nxt = LOAD_A;
                else if (unload_start_i) state_nxt = UNLOAD;
            end
            LOAD_A: begin
                sel_cur   = 2'b00;
                sect_last = (count == CW'(WORDS - 1));
                if (accept && sect_last) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                sel_cur   = 2'b01;
                sect_last = (count == CW'(WORDS - 1));
                if (accept && sect_last) state_nxt = LOAD_M;
            end
            LOAD_M: begin
                sel_cur   = 2'b10;
                sect_last = (count == CW'(WORDS - 1));
                if (accept && sect_last) state_nxt = LOAD_MP;
            end
            LOAD_MP: begin
                sel_cur   = 2'b11;
                sect_last = (count == CW'(N - 1));
                if (accept && sect_last) state_nxt = IDLE;
            end
            UNLOAD: begin
                if (xfer && m_last_o) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Counter restarts at every section boundary so each section's
        // first word is index 0.
        if (state_nxt != state)  count_nxt = '0;
        else if (accept || xfer) count_nxt = count + 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state           <= IDLE;
            count           <= '0;
            busy_o          <= 1'b0;
            INPUT_reg_en_o  <= 1'b0;
            INPUT_reg_din_o <= '0;
            INPUT_reg_sel_o <= 2'b00;
            load_done_o     <= 1'b0;
            unload_done_o   <= 1'b0;
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            busy_o          <= (state_nxt != IDLE);
            INPUT_reg_en_o  <= accept;
            INPUT_reg_din_o <= accept ? s_data_i : '0;
            INPUT_reg_sel_o <= accept ? sel_cur : 2'b00;
            // Lines up with the bank write of the final M'_0 word.
            load_done_o     <= accept && (state == LOAD_MP) && sect_last;
            unload_done_o   <= xfer && m_last_o;
        end
    end

endmodule

// File: tb/tb_poly_io_sequencer.sv
module tb_poly_io_sequencer;

    localparam int W     = 17;
    localparam int WORDS = 20;
    localparam int LOADN = 65;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          load_start_i = 1'b0;
    logic          unload_start_i = 1'b0;
    logic [W-1:0]  s_data_i = '0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [W-1:0]  m_data_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic          m_last_o;
    logic          busy_o;
    logic          load_done_o;
    logic          unload_done_o;
    logic [1:0]    INPUT_reg_sel_o;
    logic          INPUT_reg_en_o;
    logic [W-1:0]  INPUT_reg_din_o;
    logic          store_RES_reg_en_o;
    logic [W-1:0]  RES_reg_dout_i;

    poly_io_sequencer #(.WORD_WIDTH(W), .N(5), .S(4)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .load_start_i(load_start_i), .unload_start_i(unload_start_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_last_o(m_last_o), .busy_o(busy_o),
        .load_done_o(load_done_o), .unload_done_o(unload_done_o),
        .INPUT_reg_sel_o(INPUT_reg_sel_o), .INPUT_reg_en_o(INPUT_reg_en_o),
        .INPUT_reg_din_o(INPUT_reg_din_o),
        .store_RES_reg_en_o(store_RES_reg_en_o), .RES_reg_dout_i(RES_reg_dout_i)
    );

    always #5 clock_i = ~clock_i;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // RES_reg model: shifts toward word 0 on store enable
    logic [W-1:0] res_q   [WORDS];
    logic [W-1:0] pre_data[WORDS];
    logic         preload = 1'b0;
    assign RES_reg_dout_i = res_q[0];

    always @(posedge clock_i) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) res_q[i] <= pre_data[i];
        end else if (store_RES_reg_en_o) begin
            for (int i = 0; i < WORDS - 1; i++) res_q[i] <= res_q[i+1];
            res_q[WORDS-1] <= '0;
        end
    end

    // scoreboards
    logic [18:0]  ld_q[$];
    logic [W-1:0] ul_q[$];
    int ld_idx = 0, en_cnt = 0, ld_done_cnt = 0;
    int xfer_idx = 0, store_cnt = 0, ud_cnt = 0;
    bit unload_ok = 1'b0;
    bit prev_last_xfer = 1'b0;

    function automatic logic [1:0] sel_of(input int idx);
        if (idx < 20)      return 2'b00;
        else if (idx < 40) return 2'b01;
        else if (idx < 60) return 2'b10;
        else               return 2'b11;
    endfunction

    always @(negedge clock_i) begin
        logic [18:0]  e;
        logic [W-1:0] u;
        if (INPUT_reg_en_o) begin
            en_cnt++;
            if (ld_q.size() == 0) check("ld_unexpected_write", 32'(1), 32'(0));
            else begin
                e = ld_q.pop_front();
                check("ld_sel", 32'(INPUT_reg_sel_o), 32'(e[18:17]));
                check("ld_din", 32'(INPUT_reg_din_o), 32'(e[16:0]));
            end
        end
        if (load_done_o) begin
            ld_done_cnt++;
            check("ld_done_with_en", 32'(INPUT_reg_en_o), 32'(1));
            check("ld_done_all_written", 32'(ld_q.size()), 32'(0));
            check("ld_done_word_count", 32'(ld_idx), 32'(LOADN));
        end
        if (s_valid_i && s_ready_o) begin
            ld_q.push_back({sel_of(ld_idx), s_data_i});
            ld_idx++;
        end
        if (m_valid_o && !unload_ok) check("spurious_m_valid", 32'(1), 32'(0));
        if (m_valid_o && m_ready_i) begin
            check("store_on_xfer", 32'(store_RES_reg_en_o), 32'(1));
            if (ul_q.size() == 0) check("ul_extra_word", 32'(1), 32'(0));
            else begin
                u = ul_q.pop_front();
                check("ul_data", 32'(m_data_o), 32'(u));
            end
            check("ul_last", 32'(m_last_o), 32'(xfer_idx == WORDS - 1));
            xfer_idx++;
        end
        if (store_RES_reg_en_o) store_cnt++;
        if (unload_done_o) begin
            ud_cnt++;
            check("ud_after_last", 32'(prev_last_xfer), 32'(1));
        end
        prev_last_xfer = m_valid_o && m_ready_i && m_last_o;
    end

    task automatic step();
        @(posedge clock_i); #1;
    endtask

    task automatic preload_res();
        ul_q.delete();
        for (int i = 0; i < WORDS; i++) begin
            pre_data[i] = W'($urandom);
            ul_q.push_back(pre_data[i]);
        end
        preload = 1'b1;
        step();
        preload = 1'b0;
    endtask

    // Streams words until abort_at accepts (0 = full load).
    task automatic do_load(input bit bubble, input bit both_start, input bit noise,
                           input int abort_at);
        int sent, cyc;
        bit acc;
        ld_idx = 0; en_cnt = 0; ld_done_cnt = 0;
        load_start_i = 1'b1;
        unload_start_i = both_start;
        step();
        load_start_i = 1'b0;
        unload_start_i = 1'b0;
        sent = 0; cyc = 0;
        while (sent < LOADN && cyc < 400) begin
            s_valid_i = bubble ? (cyc % 2 == 0) : 1'b1;
            s_data_i  = W'($urandom);
            unload_start_i = noise && (cyc == 10);
            @(negedge clock_i);
            if (cyc == 0) check("load_s_ready", 32'(s_ready_o), 32'(1));
            acc = s_valid_i && s_ready_o;
            step();
            if (acc) sent++;
            cyc++;
            if (abort_at != 0 && sent == abort_at) break;
        end
        s_valid_i = 1'b0;
        unload_start_i = 1'b0;
        if (cyc >= 400) check("load_timeout", 32'(sent), 32'(LOADN));
    endtask

    task automatic wait_load_done();
        int c = 0;
        while (ld_done_cnt == 0 && c < 10) begin
            @(negedge clock_i);
            c++;
        end
        if (ld_done_cnt == 0) check("load_done_timeout", 32'(0), 32'(1));
    endtask

    task automatic post_load_checks(input string tag);
        step();
        @(negedge clock_i);
        check({tag, "_done_once"}, 32'(ld_done_cnt), 32'(1));
        check({tag, "_en_cycles"}, 32'(en_cnt), 32'(LOADN));
        check({tag, "_busy_idle"}, 32'(busy_o), 32'(0));
        check({tag, "_q_empty"}, 32'(ld_q.size()), 32'(0));
    endtask

    task automatic run_unload(input bit pattern);
        int cyc = 0;
        while (ud_cnt == 0 && cyc < 200) begin
            m_ready_i = pattern ? (cyc % 3 == 0) : 1'b1;
            step();
            cyc++;
        end
        m_ready_i = 1'b0;
        step();
        check("ul_words", 32'(xfer_idx), 32'(WORDS));
        check("ul_store_cycles", 32'(store_cnt), 32'(WORDS));
        check("ul_done_once", 32'(ud_cnt), 32'(1));
        check("ul_q_empty", 32'(ul_q.size()), 32'(0));
        check("ul_busy_idle", 32'(busy_o), 32'(0));
        unload_ok = 1'b0;
    endtask

    task automatic start_unload_counters();
        xfer_idx = 0; store_cnt = 0; ud_cnt = 0;
        unload_ok = 1'b1;
    endtask

    initial begin
        // reset
        repeat (3) step();
        reset_i = 1'b0;
        @(negedge clock_i);
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_s_ready", 32'(s_ready_o), 32'(0));
        check("rst_en", 32'(INPUT_reg_en_o), 32'(0));
        check("rst_m_valid", 32'(m_valid_o), 32'(0));
        check("rst_store", 32'(store_RES_reg_en_o), 32'(0));
        check("rst_load_done", 32'(load_done_o), 32'(0));
        step();

        // full load, no stalls
        do_load(1'b0, 1'b0, 1'b0, 0);
        wait_load_done();
        post_load_checks("load_plain");

        // load with bubbles
        do_load(1'b1, 1'b0, 1'b0, 0);
        wait_load_done();
        post_load_checks("load_bubble");

        // unload with backpressure 1,0,0
        preload_res();
        start_unload_counters();
        unload_start_i = 1'b1;
        step();
        unload_start_i = 1'b0;
        run_unload(1'b1);

        // simultaneous start, plus an ignored unload pulse mid-load
        do_load(1'b0, 1'b1, 1'b1, 0);
        wait_load_done();
        post_load_checks("load_both_start");

        // reset after 30 accepted words
        do_load(1'b0, 1'b0, 1'b0, 30);
        reset_i = 1'b1;
        step();
        @(negedge clock_i);
        check("abort_busy", 32'(busy_o), 32'(0));
        check("abort_s_ready", 32'(s_ready_o), 32'(0));
        check("abort_en", 32'(INPUT_reg_en_o), 32'(0));
        check("abort_load_done", 32'(ld_done_cnt), 32'(0));
        reset_i = 1'b0;
        step();
        check("abort_q_empty", 32'(ld_q.size()), 32'(0));
        do_load(1'b0, 1'b0, 1'b0, 0);
        wait_load_done();
        post_load_checks("load_after_abort");

        // back-to-back: unload requested the cycle after load_done
        preload_res();
        do_load(1'b0, 1'b0, 1'b0, 0);
        wait_load_done();
        start_unload_counters();
        step();
        unload_start_i = 1'b1;
        step();
        unload_start_i = 1'b0;
        @(negedge clock_i);
        check("b2b_m_valid", 32'(m_valid_o), 32'(1));
        check("b2b_load_done_once", 32'(ld_done_cnt), 32'(1));
        run_unload(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
